vc_plane_scheduler: RTL
=======================

# vc_plane_scheduler

Weighted round-robin scheduler for the VC planes of a router input port. Each cycle it chooses which plane's datapath (CFSM, HFB, VCG, switch control, verifier) is active. It replaces a fixed time-division rotation with one that is demand-driven and credit-aware. Planes with no flit or no downstream credit are skipped. Each granted plane holds the datapath for a programmable number of cycles.

## Interface
- `VC`, default 4: number of VC planes; legal range 2–16.
- `WEIGHT_W`, default 4: width of each per-plane weight field.
- `IDX_W`, default `$clog2(VC)`: width of the plane index.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `vcRequest`  in  VC  bit i set means plane i has a flit waiting.
- `vcCredit`  in  VC  bit i set means plane i has at least one downstream credit.
- `weightCfg`  in  VC*WEIGHT_W  weight of plane i in bits [i*WEIGHT_W +: WEIGHT_W].
- `cfgLoad`  in  1  one-cycle strobe that latches `weightCfg` into the internal weight registers.
- `planeSel`  out  IDX_W  index of the active plane.
- `planeOneHot`  out  VC  one-hot form of `planeSel`; all zero when `planeValid` is 0.
- `planeValid`  out  1  a plane is granted this cycle.
- `planeSwitch`  out  1  one-cycle pulse on the first cycle of a grant to a different plane, or of any grant that follows IDLE.

## Operation
- Eligibility: `elig[i] = vcRequest[i] & vcCredit[i] & (weight[i] != 0)`. A weight of 0 disables the plane.
- Reset weights: plane 0 = 3, all other planes = 1. Reset pointer = 0.
- FSM has two states:
  - **IDLE**: `planeValid` = 0. If any plane is eligible, grant the first eligible plane found searching upward from the pointer (with wrap), then go to HOLD.
  - **HOLD**: plane `cur` is granted and `holdCnt` counts remaining cycles. The transition rule is evaluated in the following order:
    1. If `elig[cur]` is set and `holdCnt` ≠ 0: decrement `holdCnt` and stay on `cur`.
    2. Otherwise, search for the next eligible plane starting at `cur+1` (with wrap).
       - If one is found, grant it and reload `holdCnt = weight-1`.
       - If only `cur` is eligible, re-grant `cur` and reload. `planeSwitch` stays 0.
       - If no plane is eligible, go to IDLE.
- Pointer update: on every grant, pointer = granted index + 1 (modulo VC).
- `cfgLoad` behaviour:
  - New weights apply at the next grant or reload.
  - An in-progress `holdCnt` is not altered.
  - A weight written to 0 for `cur` revokes `cur` at the next evaluation.
- Arithmetic:
  - `holdCnt` is WEIGHT_W bits wide.
  - Weight w gives exactly w consecutive granted cycles when the plane stays eligible.
  - The maximum weight is 2^WEIGHT_W − 1. There is no overflow path.
- Simultaneous `cfgLoad` and grant: the grant uses the old weights; the new weights are visible from the next cycle.

## Timing
- All outputs are registered.
- Grant latency: the decision is made on the cycle `elig` is sampled and becomes visible on `planeSel` after the next rising edge, i.e. 1-cycle latency.
- If `cur`'s eligibility drops at edge N, the new grant (or the return to IDLE) appears after edge N+1. No cycle is wasted beyond this 1-cycle latency.
- Reset values, applied asynchronously and immediately when `rst` is asserted:
  - `planeSel` = 0, `planeOneHot` = 0, `planeValid` = 0, `planeSwitch` = 0.
  - FSM = IDLE, pointer = 0, `holdCnt` = 0, weights = defaults.
- Reset mid-grant abandons the grant. The first grant after release follows the IDLE rule from pointer 0.
- `planeSwitch` is never high while `planeValid` is 0.

## Structure
- Package `vc_sched_pkg` contains:
  - the FSM state encoding (IDLE, HOLD);
  - the default weight constants (`W_PLANE0_DEF` = 3, `W_OTHER_DEF` = 1);
  - a helper for the index width.
- Sub-module `rr_next_pick` is combinational. Inputs: `VC`-bit eligibility vector and a start index. Outputs: found flag and the index of the first set bit at or above the start (with wrap). It is used for both the IDLE search and the HOLD search.
- The top level holds the FSM, `holdCnt`, the pointer, the weight registers and the output registers.

## Test plan
- **Reset defaults.** All four planes continuously eligible, default weights. Expect the repeating sequence 0,0,0,1,2,3. `planeSwitch` is high on the first cycle at 0, 1, 2 and 3.
- **Skip ineligible plane.** Clear `vcCredit[1]`. Expect the sequence 0,0,0,2,3. Plane 1 is never granted.
- **Early release.** Plane 0 is granted and drops `vcRequest` on its 2nd cycle. Expect plane 1 granted after the next edge, `planeSwitch` = 1, and `holdCnt` reloaded from weight[1].
- **Single eligible plane.** Only plane 2 eligible, weight 2. Expect `planeSel` = 2 held continuously, with `planeSwitch` pulsing only once (the first cycle after IDLE).
- **cfgLoad mid-hold.** While plane 0 is held, load weights {0:1, 1:4, 2:1, 3:0}. Expect plane 0 to finish its current 3 cycles, then 1 (×4), 2, 0 (×1), with plane 3 never granted.
- **Asynchronous reset mid-grant.** Assert `rst` between edges. Expect `planeValid` = 0 and `planeSel` = 0 immediately. After release, the first grant goes to the lowest-index eligible plane.

Source files
------------

// File: rtl/vc_sched_pkg.sv
// Shared types and constants for the VC plane scheduler.
package vc_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    localparam int W_PLANE0_DEF = 3;
    localparam int W_OTHER_DEF  = 1;

    // Index width for n planes, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Combinational wrap-around search: first set bit of elig at or above start.
module rr_next_pick
    import vc_sched_pkg::*;
#(
    parameter int VC    = 4,
    parameter int IDX_W = idx_width(VC)
) (
    input  logic [VC-1:0]    elig,
    input  logic [IDX_W-1:0] start,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scan from farthest to nearest offset so the nearest hit is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = VC - 1; k >= 0; k--) begin
            pos = IDX_W'((int'(start) + k) % VC);
            if (elig[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/vc_plane_scheduler.sv
// Weighted, credit-aware round-robin selection of the active VC plane.
//
//   state | meaning
//   IDLE  | no plane granted, search from the pointer
//   HOLD  | plane planeSel owns the datapath, holdCnt cycles remain
module vc_plane_scheduler
    import vc_sched_pkg::*;
#(
    parameter int VC       = 4,
    parameter int WEIGHT_W = 4,
    parameter int IDX_W    = idx_width(VC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VC-1:0]          vcRequest,
    input  logic [VC-1:0]          vcCredit,
    input  logic [VC*WEIGHT_W-1:0] weightCfg,
    input  logic                   cfgLoad,
    output logic [IDX_W-1:0]       planeSel,
    output logic [VC-1:0]          planeOneHot,
    output logic                   planeValid,
    output logic                   planeSwitch
);

    sched_state_t        state, state_nxt;
    logic [WEIGHT_W-1:0] weight [VC];
    logic [WEIGHT_W-1:0] holdCnt, cnt_nxt;
    logic [IDX_W-1:0]    ptr, ptr_nxt;
    logic [IDX_W-1:0]    sel_nxt;
    logic [VC-1:0]       onehot_nxt;
    logic                switch_nxt;
    logic [VC-1:0]       elig;
    logic [IDX_W-1:0]    search_start;
    logic [IDX_W-1:0]    cur_plus1;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    assign planeValid = (state == HOLD);
    assign cur_plus1  = (planeSel == IDX_W'(VC - 1)) ? '0 : planeSel + IDX_W'(1);

    // A plane competes only with a flit, a credit and a non-zero weight.
    always_comb begin
        elig = '0;
        for (int i = 0; i < VC; i++) begin
            elig[i] = vcRequest[i] & vcCredit[i] & (weight[i] != '0);
        end
    end

    // IDLE searches from the pointer; HOLD searches from the plane after cur.
    always_comb begin
        search_start = (state == IDLE) ? ptr : cur_plus1;
    end

    rr_next_pick #(
        .VC    (VC),
        .IDX_W (IDX_W)
    ) u_pick (
        .elig  (elig),
        .start (search_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state and next-output decision.
    always_comb begin
        state_nxt  = state;
        sel_nxt    = planeSel;
        cnt_nxt    = holdCnt;
        ptr_nxt    = ptr;
        switch_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt  = HOLD;
                    sel_nxt    = pick_idx;
                    cnt_nxt    = weight[pick_idx] - WEIGHT_W'(1);
                    ptr_nxt    = (pick_idx == IDX_W'(VC - 1)) ? '0 : pick_idx + IDX_W'(1);
                    switch_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (elig[planeSel] && (holdCnt != '0)) begin
                    cnt_nxt = holdCnt - WEIGHT_W'(1);
                end else if (pick_found) begin
                    sel_nxt    = pick_idx;
                    cnt_nxt    = weight[pick_idx] - WEIGHT_W'(1);
                    ptr_nxt    = (pick_idx == IDX_W'(VC - 1)) ? '0 : pick_idx + IDX_W'(1);
                    switch_nxt = (pick_idx != planeSel);
                end else begin
                    state_nxt = IDLE;
                    sel_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
        onehot_nxt = (state_nxt == HOLD) ? (VC'(1) << sel_nxt) : '0;
    end

    // State, grant outputs and hold counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            planeSel    <= '0;
            planeOneHot <= '0;
            planeSwitch <= 1'b0;
            holdCnt     <= '0;
            ptr         <= '0;
        end else begin
            state       <= state_nxt;
            planeSel    <= sel_nxt;
            planeOneHot <= onehot_nxt;
            planeSwitch <= switch_nxt;
            holdCnt     <= cnt_nxt;
            ptr         <= ptr_nxt;
        end
    end

    // Weight registers; a grant on the load edge still sees the old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VC; i++) begin
                weight[i] <= (i == 0) ? WEIGHT_W'(W_PLANE0_DEF) : WEIGHT_W'(W_OTHER_DEF);
            end
        end else if (cfgLoad) begin
            for (int i = 0; i < VC; i++) begin
                weight[i] <= weightCfg[i*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

endmodule
